// File: rtl/io_uart.sv
// rtl/io_uart.sv - memory-mapped 8N1 UART for the j1 IO bus
// RX FIFO, single-byte transmitter, sticky error flags, level interrupt.
module io_uart #(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_LOG2    = 3,
  parameter logic [15:0] ADDR_DATA    = 16'h1000,
  parameter logic [15:0] ADDR_STAT    = 16'h2000,
  parameter logic [15:0] ADDR_CTRL    = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        interrupt_request
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic w_sel_data, w_sel_stat, w_sel_ctrl;
  logic w_data_wr, w_stat_wr, w_tx_busy;
  logic w_empty, w_full, w_pop, w_push_ok;
  logic w_rx_stop_smp, w_rx_push, w_rx_ferr;
  logic [FIFO_LOG2:0] w_count;
  logic [7:0] w_head;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_LOG2:0] r_wp, r_rp;
  logic               r_overrun, r_frame_err, r_irq;
  logic [1:0]         r_ctrl;

  tx_state_t          r_tx_state;
  logic [CW-1:0]      r_tx_cnt;
  logic [2:0]         r_tx_bit;
  logic [7:0]         r_tx_shift;
  logic               r_tx;

  rx_state_t          r_rx_state;
  logic [1:0]         r_rx_sync;
  logic [CW-1:0]      r_rx_cnt;
  logic [2:0]         r_rx_bit;
  logic [7:0]         r_rx_shift;
  logic               r_rx_hold;

  assign w_sel_data = (io_addr == ADDR_DATA);
  assign w_sel_stat = (io_addr == ADDR_STAT);
  assign w_sel_ctrl = (io_addr == ADDR_CTRL);
  assign w_tx_busy  = (r_tx_state != TX_IDLE);
  assign w_data_wr  = io_wr & w_sel_data & ~w_tx_busy;
  assign w_stat_wr  = io_wr & w_sel_stat;

  assign w_count   = r_wp - r_rp;
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (w_count == (FIFO_LOG2 + 1)'(DEPTH));
  assign w_head    = r_mem[r_rp[FIFO_LOG2-1:0]];
  assign w_pop     = io_rd & w_sel_data & ~w_empty;
  assign w_push_ok = w_rx_push & (~w_full | w_pop);

  assign w_rx_stop_smp = (r_rx_state == RX_STOP) && (r_rx_cnt == C_LAST);
  assign w_rx_push     = w_rx_stop_smp & r_rx_sync[1];
  assign w_rx_ferr     = w_rx_stop_smp & ~r_rx_sync[1];

  assign uart_tx           = r_tx;
  assign interrupt_request = r_irq;

  always_comb begin
    io_din = 16'h0000;
    if (w_sel_data && !w_empty) io_din = {8'h00, w_head};
    else if (w_sel_stat)        io_din = {11'b0, r_frame_err, r_overrun, w_full, ~w_empty, w_tx_busy};
    else if (w_sel_ctrl)        io_din = {14'b0, r_ctrl};
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp[FIFO_LOG2-1:0]] <= r_rx_shift;
  end

  // Push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_ctrl      <= 2'b00;
      r_irq       <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + (FIFO_LOG2 + 1)'(1);
      if (w_pop)     r_rp <= r_rp + (FIFO_LOG2 + 1)'(1);
      if (w_rx_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (w_stat_wr && io_dout[3])  r_overrun <= 1'b0;
      if (w_rx_ferr)                     r_frame_err <= 1'b1;
      else if (w_stat_wr && io_dout[4])  r_frame_err <= 1'b0;
      if (io_wr && w_sel_ctrl) r_ctrl <= io_dout[1:0];
      r_irq <= (r_ctrl[0] & ~w_empty) | (r_ctrl[1] & ~w_tx_busy);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_tx     <= 1'b1;
          r_tx_cnt <= '0;
          r_tx_bit <= 3'd0;
          if (w_data_wr) begin
            r_tx_shift <= io_dout[7:0];
            r_tx       <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else r_tx_cnt <= r_tx_cnt + CW'(1);
        end
        TX_DATA: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt + CW'(1);
        end
        TX_STOP: begin
          if (r_tx_cnt == C_LAST) r_tx_state <= TX_IDLE;
          else                    r_tx_cnt   <= r_tx_cnt + CW'(1);
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // After a framing error the line may still be low; r_rx_hold blocks a bogus restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_hold  <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], uart_rx};
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= 3'd0;
          if (r_rx_hold) begin
            if (r_rx_sync[1]) r_rx_hold <= 1'b0;
          end else if (!r_rx_sync[1]) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == C_HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_sync[1] ? RX_IDLE : RX_DATA;
          end else r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        RX_DATA: begin
          if (r_rx_cnt == C_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync[1], r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        RX_STOP: begin
          if (r_rx_cnt == C_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (!r_rx_sync[1]) r_rx_hold <= 1'b1;
          end else r_rx_cnt <= r_rx_cnt + CW'(1);
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_uart.md
# io_uart

Memory-mapped 8N1 UART for the j1 core's IO bus: 8-bit data, no parity, one stop bit. It decodes `io_rd`/`io_wr`/`io_addr`, drives `io_din` back to the CPU, and raises `interrupt_request`. It has an RX FIFO, a single-byte transmitter and sticky error flags. `io_din` is zero when the block is not addressed, so several peripherals can be ORed onto the CPU's read bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200); legal range ≥ 4.
- `FIFO_LOG2`, 3: RX FIFO depth is 2^FIFO_LOG2 entries.
- `ADDR_DATA`, 16'h1000: data register address.
- `ADDR_STAT`, 16'h2000: status register address.
- `ADDR_CTRL`, 16'h4000: control register address.

Ports:
- `clk` in 1: the single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `io_rd` in 1: CPU read strobe, one cycle.
- `io_wr` in 1: CPU write strobe, one cycle.
- `io_addr` in 16: register address, full 16-bit compare.
- `io_dout` in 16: CPU write data.
- `io_din` out 16: read data; combinational from `io_addr`.
- `uart_rx` in 1: asynchronous serial input, idle high.
- `uart_tx` out 1: serial output, registered, idle high.
- `interrupt_request` out 1: level interrupt to the CPU.

## Operation
- Reset values: `uart_tx`=1, `interrupt_request`=0, `io_din`=0 when not addressed. FIFO empty, TX idle, RX idle, all flags clear, control register 0.
- DATA read: `io_din`={8'h00, FIFO head}. If `io_rd` is high and the FIFO is non-empty, the FIFO pops at the clock edge. An empty read returns 16'h0000 and pops nothing.
- DATA write while TX is idle: `io_dout[7:0]` is latched and TX starts. A write while TX is busy is ignored: no queueing, no flag.
- STAT read: `io_din` = {11'b0, frame_err, overrun, rx_full, rx_avail, tx_busy} (bits 4..0). Reads have no side effects.
- STAT write clears sticky flags write-1-to-clear: `io_dout[3]` clears overrun, `io_dout[4]` clears frame_err.
- CTRL: bit0 = rx_ie, bit1 = tx_ie; read-back in `io_din[1:0]`, upper bits read 0.
- `interrupt_request` = (rx_ie & rx_avail) | (tx_ie & ~tx_busy), registered. The CPU disables interrupts on entry, so a level request is safe.
- TX FSM:
  - States IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state lasts CLKS_PER_BIT cycles; an internal bit counter counts 0..7.
- RX FSM:
  - `uart_rx` passes through a 2-flop synchroniser.
  - IDLE → START on a synchronised low.
  - START: at CLKS_PER_BIT/2 (integer divide) the line is re-sampled. Still low → DATA; high → false start, return to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT, LSB first, 8 bits.
  - STOP: sample one CLKS_PER_BIT later. High → push the byte. Low → set frame_err, discard the byte, and wait in IDLE until the line is high.
- FIFO push when full: the byte is dropped, overrun is set, and existing contents are unchanged.
- Simultaneous pop and push on a full FIFO: both occur, no overrun.
- Pointers are FIFO_LOG2+1 bits and wrap naturally. rx_full = depth reached; rx_avail = non-empty.
- Reset mid-frame: both FSMs abort to IDLE and `uart_tx` returns to 1 asynchronously. Bytes in flight are lost.
- `io_rd`/`io_wr` with a non-matching `io_addr`: no effect.

## Timing
- Register writes take effect at the edge where `io_wr` is high and are visible to reads from the next cycle.
- `io_din` is valid in the same cycle as `io_addr`/`io_rd`; the j1 captures it at that edge.
- TX:
  - `uart_tx` falls one cycle after the DATA-write edge.
  - `tx_busy` reads 1 from the cycle after the write.
  - The frame lasts 10·CLKS_PER_BIT cycles; `tx_busy` drops at the end of the stop bit.
  - A new write is accepted in the same cycle `tx_busy` reads 0.
- RX:
  - Falling edge to START detect: 2 cycles (synchroniser).
  - The byte appears in the FIFO (rx_avail=1) at the mid-stop-bit sample, about 2 + 9.5·CLKS_PER_BIT cycles after the start edge.
- `interrupt_request` lags the flag and control state by 1 cycle.

## Test plan
- Reset, then TX: write DATA=0x0055 with CLKS_PER_BIT=8. `uart_tx` must show start 0, then bits 1,0,1,0,1,0,1,0, then stop 1, each exactly 8 cycles. `tx_busy`=1 for 80 cycles, then 0. A second write during busy changes nothing.
- RX: drive 0xA3 on `uart_rx` at 8 cycles/bit. STAT must read 0x0002, then DATA reads 0x00A3 and STAT returns to 0x0000. A 3-cycle low glitch is ignored as a false start: no byte, no flag.
- Overrun: receive 9 bytes into an 8-deep FIFO without reading. rx_full=1 and overrun=1; reads return the first 8 bytes in order; the 9th is lost. A STAT write of 0x0008 clears overrun.
- Framing: send 0x3C with stop bit 0. frame_err=1, no FIFO push; a STAT write of 0x0010 clears it.
- Interrupts: set CTRL=0x0001, receive one byte; `interrupt_request` rises 1 cycle after rx_avail and drops 1 cycle after the pop. Then CTRL=0x0002 while idle: request=1; request=0 during TX.
- Assert `reset` mid-TX and mid-RX: `uart_tx`=1 immediately, all registers 0, and the next frame after release is received correctly.
